commit_trace_buffer: RTL
========================

Name: commit_trace_buffer

Overview:
Synthesizable commit monitor for the barrel-threaded RISC-V core. Captures per-thread register-file write-backs and data-memory writes, tags each with thread index and cycle stamp, and buffers the records in a FIFO. A first-word-fall-through valid/ready port drains the FIFO to a debug UART, an MMIO reader or a bench scoreboard. It generalises register/memory dump monitoring to any thread count, address width and depth, and adds thread filtering, back-pressure and overflow accounting.

Parameters:
NUM_THREADS, 16, number of hardware threads; THREAD_W = $clog2(NUM_THREADS)
DATA_W, 32, register and memory data width
REG_ADDR_W, 5, register-file address width
MEM_ADDR_W, 14, data-memory address width; must be >= REG_ADDR_W
DEPTH, 16, FIFO entries; power of 2, >= 4
TS_W, 16, cycle-stamp width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_enable  in  1  global capture enable
i_thread_mask  in  NUM_THREADS  bit t=1 enables capture for thread t
regfile_wr_en  in  1  write-back enable
regfile_wr_addr  in  REG_ADDR_W  write-back register
regfile_wr_data  in  DATA_W  write-back data
thread_index_wb  in  THREAD_W  write-back thread
dmem_write_enable  in  DATA_W/8  byte write enables
dmem_addr  in  MEM_ADDR_W  memory word address
dmem_write_data  in  DATA_W  memory write data
thread_index_wrmem  in  THREAD_W  memory-write thread
o_trace_valid  out  1  head record valid
o_trace_data  out  REC_W  head record
i_trace_ready  in  1  consumer accepts head
o_fill_level  out  $clog2(DEPTH+1)  occupied entries
o_overflow  out  1  sticky: at least one record dropped
o_drop_count  out  16  dropped records, saturating
i_clear_overflow  in  1  clears o_overflow and o_drop_count

Behaviour:
- Record, MSB to LSB: {type(1: 0=reg, 1=mem), thread(THREAD_W), addr(MEM_ADDR_W; reg addr zero-extended), data(DATA_W), be(DATA_W/8; reg records all ones), stamp(TS_W)}. REC_W is the sum of these fields.
- Stamp: free-running counter. 0 after reset, +1 every cycle, wraps at 2^TS_W. A record carries the stamp of its capture cycle.
- Reg event: i_enable & regfile_wr_en & (regfile_wr_addr != 0) & i_thread_mask[thread_index_wb].
- Mem event: i_enable & (|dmem_write_enable) & i_thread_mask[thread_index_wrmem].
- Inputs are sampled at the clk edge. Neither port is registered before capture.
- Both events in one cycle: two records are pushed in that cycle, reg record first (closer to head).
- Space check uses free = DEPTH - count at the start of the cycle. A pop in the same cycle does not create space for that cycle's pushes.
- free >= needed: push all records. free == 1 with two events: push reg, drop mem. free == 0: drop all.
- Each dropped record adds 1 to o_drop_count, saturating at 16'hFFFF, and sets o_overflow.
- i_clear_overflow zeroes both. If a drop happens in the same cycle as a clear, the drop wins: overflow=1 and count = number dropped that cycle.
- Output is first-word-fall-through: o_trace_valid = (count != 0), and o_trace_data = head entry, combinational from the storage registers.
- Pop happens on o_trace_valid & i_trace_ready. Ready while not valid is ignored.
- o_trace_data must hold stable while valid & !ready.
- Latency: event captured at edge N is visible on the output after edge N when the FIFO was empty (one cycle).
- count next = count + pushes - pop. Range 0..DEPTH. Read and write pointers wrap modulo DEPTH.
- Reset, including mid-stream: count, pointers, stamp, o_overflow and o_drop_count go to 0; o_trace_valid=0; o_trace_data=0. FIFO contents are discarded. No capture happens in a reset cycle.
- Deasserting i_enable stops capture only. The FIFO keeps draining.

Test Plan:
- Reset, then thread 3 writes x5=0x1234 at stamp 10 -> one record {0,3,5,0x1234,0xF,10}; valid next cycle; fill_level 1 -> 0 on ready.
- Reg write to x0, plus a mem write from thread 7 with mask bit 7=0 -> no records, fill_level stays 0.
- Same cycle: reg (thread 1, x2=0xA) and mem (thread 2, addr 0x40, be 0x3, 0xBEEF) -> two records, reg first, identical stamps, fill_level 2.
- i_trace_ready=0 with 15 entries, then dual event -> reg pushed, mem dropped, drop_count 1, overflow 1. Next dual event -> drop_count 3. i_clear_overflow -> 0/0.
- Full FIFO, ready=1 and one event in the same cycle -> event dropped, fill_level becomes 15, head data held stable while ready=0.
- Reset asserted with 8 entries queued -> valid 0, fill_level 0, stamp restarts at 0; after 2^16 cycles the stamp wraps to 0.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Commit monitor for the barrel-threaded core. Captures register-file write-backs and
//   data-memory writes, tags each with thread index and cycle stamp, and queues the records
//   in a FIFO. The FIFO drains through a first-word-fall-through valid/ready port.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   i_enable              global capture enable
//   i_thread_mask         per-thread capture enable
//   regfile_wr_*          write-back port (en, addr, data), thread_index_wb
//   dmem_*                memory write port (byte enables, word addr, data), thread_index_wrmem
//   o_trace_valid/data    head record, i_trace_ready pops it
//   o_fill_level          occupied entries
//   o_overflow            sticky drop flag
//   o_drop_count          saturating drop counter
//   i_clear_overflow      clears o_overflow and o_drop_count
//
// Record layout, MSB to LSB: {type, thread, addr, data, be, stamp}.
module commit_trace_buffer #(
  parameter int unsigned NUM_THREADS = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_ADDR_W  = 14,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TS_W        = 16,
  localparam int unsigned THREAD_W   = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int unsigned BE_W       = DATA_W / 8,
  localparam int unsigned REC_W      = 1 + THREAD_W + MEM_ADDR_W + DATA_W + BE_W + TS_W,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enable,
  input  logic [NUM_THREADS-1:0] i_thread_mask,
  input  logic                   regfile_wr_en,
  input  logic [REG_ADDR_W-1:0]  regfile_wr_addr,
  input  logic [DATA_W-1:0]      regfile_wr_data,
  input  logic [THREAD_W-1:0]    thread_index_wb,
  input  logic [BE_W-1:0]        dmem_write_enable,
  input  logic [MEM_ADDR_W-1:0]  dmem_addr,
  input  logic [DATA_W-1:0]      dmem_write_data,
  input  logic [THREAD_W-1:0]    thread_index_wrmem,
  output logic                   o_trace_valid,
  output logic [REC_W-1:0]       o_trace_data,
  input  logic                   i_trace_ready,
  output logic [CNT_W-1:0]       o_fill_level,
  output logic                   o_overflow,
  output logic [15:0]            o_drop_count,
  input  logic                   i_clear_overflow
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [TS_W-1:0]  r_stamp;
  logic             r_overflow;
  logic [15:0]      r_drop_count;

  logic             w_reg_ev;
  logic             w_mem_ev;
  logic             w_push_reg;
  logic             w_push_mem;
  logic             w_pop;
  logic [CNT_W-1:0] w_free;
  logic [1:0]       w_n_push;
  logic [1:0]       w_n_drop;
  logic [PTR_W-1:0] w_mem_ptr;
  logic [REC_W-1:0] w_reg_rec;
  logic [REC_W-1:0] w_mem_rec;
  logic [16:0]      w_drop_sum;

  assign w_reg_ev = i_enable & regfile_wr_en & (regfile_wr_addr != '0) &
                    i_thread_mask[thread_index_wb];
  assign w_mem_ev = i_enable & (|dmem_write_enable) & i_thread_mask[thread_index_wrmem];

  // Free space is taken from the count at the start of the cycle; a same-cycle pop does not
  // make room for this cycle's pushes.
  assign w_free     = DEPTH_C - r_count;
  assign w_push_reg = w_reg_ev & (w_free != '0);
  assign w_push_mem = w_mem_ev & (w_reg_ev ? (w_free >= CNT_W'(2)) : (w_free != '0));
  assign w_n_push   = {1'b0, w_push_reg} + {1'b0, w_push_mem};
  assign w_n_drop   = {1'b0, w_reg_ev & ~w_push_reg} + {1'b0, w_mem_ev & ~w_push_mem};
  assign w_pop      = (r_count != '0) & i_trace_ready;

  // Reg record sits in the first slot, so the mem record goes one slot further when both push.
  assign w_mem_ptr  = r_wptr + PTR_W'(w_push_reg);
  assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_n_drop);

  assign w_reg_rec = {1'b0, thread_index_wb, MEM_ADDR_W'(regfile_wr_addr), regfile_wr_data,
                      {BE_W{1'b1}}, r_stamp};
  assign w_mem_rec = {1'b1, thread_index_wrmem, dmem_addr, dmem_write_data, dmem_write_enable,
                      r_stamp};

  // Storage has no reset; stale contents are never visible because output is gated by count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_push_reg) r_mem[r_wptr] <= w_reg_rec;
      if (w_push_mem) r_mem[w_mem_ptr] <= w_mem_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_stamp      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_stamp <= r_stamp + 1'b1;
      r_wptr  <= r_wptr + PTR_W'(w_n_push);
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
      // A drop in the same cycle as a clear survives the clear.
      if (i_clear_overflow) begin
        r_overflow   <= (w_n_drop != '0);
        r_drop_count <= 16'(w_n_drop);
      end else begin
        if (w_n_drop != '0) r_overflow <= 1'b1;
        r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end

  assign o_trace_valid = (r_count != '0);
  assign o_trace_data  = o_trace_valid ? r_mem[r_rptr] : '0;
  assign o_fill_level  = r_count;
  assign o_overflow    = r_overflow;
  assign o_drop_count  = r_drop_count;

endmodule
